dcache_wb_direct: RTL

Write-back, write-allocate, direct-mapped data cache that answers the pipeline's D-cache requests (`DCACHE_ren/wen/addr/wdata` to `proc_*`) and fills and evicts 4-word blocks from a slow 128-bit memory port. It sits between the CPU core and the memory model in the top-level wrapper. On a hit it answers in the same cycle. On a miss it holds `proc_stall` high until the block is resident. Data is stored exactly as received; the core does any byte swapping.

---
 rtl/dcache_wb_direct.sv | 127 ++++++++++++
 1 files changed

// File: rtl/dcache_wb_direct.sv
// Write-back, write-allocate, direct-mapped data cache with 4-word lines.
// Hits are served combinationally. Misses stall the core while a dirty victim is
// written back and the missing block is fetched over a 128-bit memory port.
module dcache_wb_direct #(
    parameter int unsigned NUM_BLOCK = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic         proc_stall,
    output logic [31:0]  proc_rdata,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic         mem_ready,
    input  logic [127:0] mem_rdata
);

    localparam int unsigned IDX = $clog2(NUM_BLOCK);
    localparam int unsigned TAG = 28 - IDX;

    typedef enum logic [1:0] {StCompare, StWriteback, StAllocate} state_e;

    state_e state_q, state_d;

    logic [NUM_BLOCK-1:0] valid_q;
    logic [NUM_BLOCK-1:0] dirty_q;
    logic [TAG-1:0]       tag_q  [NUM_BLOCK];
    logic [127:0]         data_q [NUM_BLOCK];

    logic [IDX-1:0] idx;
    logic [TAG-1:0] req_tag;
    logic [1:0]     word;
    logic           req;
    logic           hit;
    logic           write_hit;
    logic           fill;

    assign idx     = proc_addr[IDX+1:2];
    assign req_tag = proc_addr[29:IDX+2];
    assign word    = proc_addr[1:0];
    assign req     = proc_read | proc_write;
    assign hit     = valid_q[idx] & (tag_q[idx] == req_tag);

    // Simultaneous read and write is served as a write.
    assign write_hit = (state_q == StCompare) & proc_write & hit;
    assign fill      = (state_q == StAllocate) & mem_ready;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StCompare;
        end else begin
            state_q <= state_d;
        end
    end

    // Line storage: write hits update one word, fills replace the whole line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
            for (int unsigned i = 0; i < NUM_BLOCK; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else if (fill) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
            tag_q[idx]   <= req_tag;
            data_q[idx]  <= mem_rdata;
        end else if (write_hit) begin
            dirty_q[idx]                    <= 1'b1;
            data_q[idx][{word, 5'b0} +: 32] <= proc_wdata;
        end
    end

    // Next-state and outputs; every output idles at zero unless actively driven.
    always_comb begin
        state_d    = state_q;
        proc_stall = 1'b0;
        proc_rdata = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_q)
            StCompare: begin
                if (req) begin
                    if (hit) begin
                        if (!proc_write) begin
                            proc_rdata = data_q[idx][{word, 5'b0} +: 32];
                        end
                    end else begin
                        proc_stall = 1'b1;
                        state_d    = (valid_q[idx] & dirty_q[idx]) ? StWriteback : StAllocate;
                    end
                end
            end
            StWriteback: begin
                proc_stall = 1'b1;
                mem_write  = 1'b1;
                mem_addr   = {tag_q[idx], idx};
                mem_wdata  = data_q[idx];
                if (mem_ready) begin
                    state_d = StAllocate;
                end
            end
            StAllocate: begin
                proc_stall = 1'b1;
                mem_read   = 1'b1;
                mem_addr   = proc_addr[29:2];
                if (mem_ready) begin
                    state_d = StCompare;
                end
            end
            default: begin
                state_d = StCompare;
            end
        endcase
    end

endmodule
